// File: rtl/cim_pkg.sv
// Shared constants and helpers for the CIM result path.
package cim_pkg;

   localparam int CIM_IN_W  = 51;
   localparam int CIM_OUT_W = 32;

   // Largest value representable as a signed w-bit number (w <= 63).
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Smallest value representable as a signed w-bit number (w <= 63).
   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/cim_result_collector_if.sv
// Valid/ready result stream carrying formatted data, a clamp flag and a sequence tag.
interface cim_result_collector_if
   import cim_pkg::*;
#(
   parameter int OUT_W = CIM_OUT_W,
   parameter int TAG_W = 8
);
   logic             res_valid;
   logic             res_ready;
   logic [OUT_W-1:0] res_data;
   logic             res_sat;
   logic [TAG_W-1:0] res_tag;

   modport master (
      output res_valid,
      output res_data,
      output res_sat,
      output res_tag,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_data,
      input  res_sat,
      input  res_tag,
      output res_ready
   );
endinterface

// File: rtl/cim_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output. Pointers carry one extra
// bit so that full and empty can be told apart when the indices coincide.
module cim_sync_fifo
   import cim_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level    = wr_ptr - rd_ptr;
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Advance the read and write pointers; a push into a full FIFO only lands if the head leaves on the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset because the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cim_result_collector.sv
// Captures the CIM accumulator on each rising edge of st, shifts and
// saturates/truncates it, tags it and buffers it for a valid/ready consumer.
module cim_result_collector
   import cim_pkg::*;
#(
   parameter int IN_W  = CIM_IN_W,
   parameter int OUT_W = CIM_OUT_W,
   parameter int SHIFT = 0,
   parameter int SAT   = 1,
   parameter int DEPTH = 4,
   parameter int TAG_W = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       st,
   input  logic [IN_W-1:0]            nout,
   input  logic                       ovf_clr,
   cim_result_collector_if.master     res_if,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf
);

   localparam int FW = OUT_W + 1 + TAG_W;
   localparam logic signed [IN_W-1:0] V_MAX = IN_W'(sat_max(OUT_W));
   localparam logic signed [IN_W-1:0] V_MIN = IN_W'(sat_min(OUT_W));

   logic                    st_q;
   logic                    capture;
   logic [IN_W-1:0]         stage_raw;
   logic [TAG_W-1:0]        stage_tag;
   logic                    stage_vld;
   logic [TAG_W-1:0]        tag_cnt;
   logic signed [IN_W-1:0]  v;
   logic [OUT_W-1:0]        fmt_data;
   logic                    fmt_sat;
   logic [FW-1:0]           head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;

   assign capture = st && !st_q;
   assign pop     = res_if.res_valid && res_if.res_ready;

   // Remember the previous st level so a held-high strobe produces a single capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) st_q <= 1'b0;
      else       st_q <= st;
   end

   // Latch the raw result with the next sequence tag; the tag advances even if the result is later dropped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stage_raw <= '0;
         stage_tag <= '0;
         tag_cnt   <= '0;
         stage_vld <= 1'b0;
      end else begin
         stage_vld <= capture;
         if (capture) begin
            stage_raw <= nout;
            stage_tag <= tag_cnt;
            tag_cnt   <= tag_cnt + 1'b1;
         end
      end
   end

   // Arithmetic shift, then clamp to the signed output range or keep the low bits.
   always_comb begin
      v        = $signed(stage_raw) >>> SHIFT;
      fmt_data = v[OUT_W-1:0];
      fmt_sat  = 1'b0;
      if (SAT != 0) begin
         if (v > V_MAX) begin
            fmt_data = {1'b0, {(OUT_W-1){1'b1}}};
            fmt_sat  = 1'b1;
         end else if (v < V_MIN) begin
            fmt_data = {1'b1, {(OUT_W-1){1'b0}}};
            fmt_sat  = 1'b1;
         end
      end
   end

   // Sticky overflow: a staged result that finds the FIFO full with no pop is lost; setting beats clearing.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                ovf <= 1'b0;
      else if (stage_vld && fifo_full && !pop)  ovf <= 1'b1;
      else if (ovf_clr)                         ovf <= 1'b0;
   end

   cim_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (stage_vld),
      .push_data ({fmt_data, fmt_sat, stage_tag}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   assign res_if.res_valid = !fifo_empty;
   assign res_if.res_data  = head[FW-1 -: OUT_W];
   assign res_if.res_sat   = head[TAG_W];
   assign res_if.res_tag   = head[TAG_W-1:0];

endmodule
